// File: rtl/fir_cfg_sequencer_if.sv
// ---------------------------------------------------------------------------
// fir_cfg_sequencer_if
//   Bundles the config-FIFO read port, the filter handshake and the FIR
//   register-bank write port used by fir_cfg_sequencer.
//
//   FIFO side     : Empty, Data (show-ahead), RINC (pop strobe)
//   Filter side   : iHold (filter busy), iErrClr (clear sticky error)
//   Register bank : WrEn, RegAddr, D7_D0
//   Status        : oCommit, oBusy, oErr
//
//   modport master : the sequencer (drives RINC, the register port, status)
//   modport slave  : the environment (FIFO + filter)
// ---------------------------------------------------------------------------
interface fir_cfg_sequencer_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);
  logic              Empty;
  logic [DATA_W-1:0] Data;
  logic              RINC;
  logic              iHold;
  logic              iErrClr;
  logic              WrEn;
  logic [ADDR_W-1:0] RegAddr;
  logic [DATA_W-1:0] D7_D0;
  logic              oCommit;
  logic              oBusy;
  logic              oErr;

  modport master (
    input  Empty, Data, iHold, iErrClr,
    output RINC, WrEn, RegAddr, D7_D0, oCommit, oBusy, oErr
  );

  modport slave (
    output Empty, Data, iHold, iErrClr,
    input  RINC, WrEn, RegAddr, D7_D0, oCommit, oBusy, oErr
  );
endinterface : fir_cfg_sequencer_if

// File: rtl/fir_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// fir_cfg_sequencer
//   Parses byte packets from a show-ahead config FIFO and writes them into
//   the FIR filter's register bank.
//
//   Packet : header byte, then N data bytes.
//     header[7]   marker, must be 1 (otherwise the byte is dropped, oErr set)
//     header[6:4] start register address
//     header[3]   commit flag (oCommit pulses after the last write)
//     header[2:0] N-1
//   Data bytes go to consecutive addresses (wrapping), one WrEn each.
//
//   Ports:
//     CLK   clock (same as the FIFO read clock)
//     RSTn  asynchronous active-low reset
//     bus   fir_cfg_sequencer_if.master: FIFO read port, iHold/iErrClr,
//           register write port and status flags
//
//   RINC is combinational (state, Empty, iHold); every other output is a
//   flop.
//
//   Optional build macro CFG_TIMEOUT_EN: adds a starvation counter in LOAD.
//   After TIMEOUT_CYC consecutive cycles with Empty=1 and iHold=0 the packet
//   is abandoned (oErr set, no commit). Without the macro LOAD waits
//   forever and TIMEOUT_CYC does not exist.
// ---------------------------------------------------------------------------
module fir_cfg_sequencer #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
`ifdef CFG_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 255
`endif
) (
  input logic                 CLK,
  input logic                 RSTn,
  fir_cfg_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WR,
    S_COMMIT
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;         // address of the next data byte
  logic [2:0]        cnt;          // data bytes still to write, minus one
  logic              commit_flag;
  logic              wr_en;
  logic              commit;
  logic              busy;
  logic              err;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_data;

  logic              pop;
  logic              hdr_bad;
  logic              tmo_hit;
  logic              err_set;

  // A byte is consumed only in the two states that read the FIFO, never
  // while the filter holds us off, and never while reset is asserted (the
  // FIFO may still show data during our reset).
  assign pop = RSTn && !bus.Empty && !bus.iHold &&
               ((state == S_IDLE) || (state == S_LOAD));

  assign hdr_bad = pop && (state == S_IDLE) && !bus.Data[7];

`ifdef CFG_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo;
  logic             starve;

  assign starve  = (state == S_LOAD) && bus.Empty && !bus.iHold;
  // Fires on the TIMEOUT_CYC-th starved cycle; the transition happens on
  // the following edge.
  assign tmo_hit = starve && (tmo == TMO_W'(TIMEOUT_CYC - 1));

  // Counts only while starved; frozen while iHold keeps us waiting, cleared
  // by any pop or by being outside LOAD.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      tmo <= '0;
    end else if ((state != S_LOAD) || pop || tmo_hit) begin
      tmo <= '0;
    end else if (starve) begin
      tmo <= tmo + TMO_W'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  assign err_set = hdr_bad || tmo_hit;

  // NOTE: every flop here uses non-blocking assignment so all of them sample
  // the pre-edge values; a blocking '=' would let later statements see
  // already-updated state and change behaviour with statement order.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state       <= S_IDLE;
      addr        <= '0;
      cnt         <= '0;
      commit_flag <= 1'b0;
      wr_en       <= 1'b0;
      commit      <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
      reg_addr    <= '0;
      reg_data    <= '0;
    end else begin
      // Strobes default low so each is high for exactly one cycle.
      wr_en  <= 1'b0;
      commit <= 1'b0;

      // A new error outranks a simultaneous clear request.
      if (err_set) begin
        err <= 1'b1;
      end else if (bus.iErrClr) begin
        err <= 1'b0;
      end

      unique case (state)
        S_IDLE: begin
          if (pop && bus.Data[7]) begin
            addr        <= bus.Data[4 +: ADDR_W];
            cnt         <= bus.Data[2:0];
            commit_flag <= bus.Data[3];
            state       <= S_LOAD;
            busy        <= 1'b1;
          end
        end

        S_LOAD: begin
          if (pop) begin
            reg_data <= bus.Data;
            reg_addr <= addr;
            wr_en    <= 1'b1;
            state    <= S_WR;
          end else if (tmo_hit) begin
            cnt   <= '0;
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end

        S_WR: begin
          if (cnt == 3'd0) begin
            if (commit_flag) begin
              commit <= 1'b1;
              state  <= S_COMMIT;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt   <= cnt - 3'd1;
            addr  <= addr + ADDR_W'(1);   // wraps modulo the bank size
            state <= S_LOAD;
          end
        end

        S_COMMIT: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.RINC    = pop;
  assign bus.WrEn    = wr_en;
  assign bus.RegAddr = reg_addr;
  assign bus.D7_D0   = reg_data;
  assign bus.oCommit = commit;
  assign bus.oBusy   = busy;
  assign bus.oErr    = err;

endmodule : fir_cfg_sequencer

// File: tb/tb_fir_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fir_cfg_sequencer
//   Directed bench for fir_cfg_sequencer. A packet-level model parses every
//   byte pushed into the bench FIFO and queues the register writes, commit
//   strobes and error events it implies; a per-cycle monitor matches DUT
//   events against that queue. Directed checks pin latencies, addresses and
//   data with hand-computed literals.
// ---------------------------------------------------------------------------
module tb_fir_cfg_sequencer;

  logic CLK = 1'b0;
  logic RSTn;

  always #5 CLK = ~CLK;

  fir_cfg_sequencer_if #(.ADDR_W(3), .DATA_W(8)) bus ();

  fir_cfg_sequencer #(
    .ADDR_W(3),
    .DATA_W(8)
`ifdef CFG_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(16)
`endif
  ) dut (
    .CLK (CLK),
    .RSTn(RSTn),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- bench FIFO (show-ahead) ----------------
  logic [7:0] fifo_q[$];
  bit         pop_pending;

  task automatic drive_fifo();
    bus.Empty = (fifo_q.size() == 0);
    bus.Data  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  endtask

  // ---------------- packet-level model ----------------
  typedef enum {EV_WR, EV_COMMIT, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [2:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  int         p_left   = 0;    // data bytes still owed by the current packet
  logic [2:0] p_addr   = '0;
  bit         p_commit = 1'b0;

  task automatic model_byte(input logic [7:0] b);
    ev_t e;
    if (p_left == 0) begin
      if (!b[7]) begin
        e.kind = EV_ERR; e.addr = '0; e.data = '0;
        exp_q.push_back(e);
      end else begin
        p_addr   = b[6:4];
        p_commit = b[3];
        p_left   = int'(b[2:0]) + 1;
      end
    end else begin
      e.kind = EV_WR; e.addr = p_addr; e.data = b;
      exp_q.push_back(e);
      p_addr = p_addr + 3'd1;
      p_left--;
      if (p_left == 0 && p_commit) begin
        e.kind = EV_COMMIT; e.addr = '0; e.data = '0;
        exp_q.push_back(e);
      end
    end
  endtask

  // Packet starved out: the rest of it never arrives and an error is due.
  task automatic model_timeout();
    ev_t e;
    e.kind = EV_ERR; e.addr = '0; e.data = '0;
    exp_q.push_back(e);
    p_left = 0;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    model_byte(b);
    drive_fifo();
  endtask

  // ---------------- monitor / scoreboard ----------------
  int         n = 0;              // sample (cycle) index
  bit         busy_hist[0:4095];
  int         rinc_log[$];
  int         wr_log[$];
  int         commit_log[$];
  int         err_log[$];
  logic [2:0] wr_addr_log[$];
  logic [7:0] wr_data_log[$];
  bit         prev_wr  = 1'b0;
  bit         prev_err = 1'b0;

  task automatic sample();
    n++;
    if (n < 4096) busy_hist[n] = bus.oBusy;
    pop_pending = (bus.RINC === 1'b1);
    if (!RSTn) begin
      prev_wr  = 1'b0;
      prev_err = 1'b0;
      return;
    end
    if (bus.RINC === 1'b1) begin
      rinc_log.push_back(n);
      check("rinc_while_empty", bus.Empty, 1'b0);
      check("rinc_while_hold", bus.iHold, 1'b0);
    end
    if (bus.WrEn === 1'b1) begin
      wr_log.push_back(n);
      wr_addr_log.push_back(bus.RegAddr);
      wr_data_log.push_back(bus.D7_D0);
      check("wren_single_cycle", prev_wr, 1'b0);
      check("sb_write_expected", (exp_q.size() > 0 && exp_q[0].kind == EV_WR), 1'b1);
      if (exp_q.size() > 0 && exp_q[0].kind == EV_WR) begin
        check("sb_wr_addr", bus.RegAddr, exp_q[0].addr);
        check("sb_wr_data", bus.D7_D0, exp_q[0].data);
        void'(exp_q.pop_front());
      end
    end
    if (bus.oCommit === 1'b1) begin
      commit_log.push_back(n);
      check("commit_follows_last_wr", prev_wr, 1'b1);
      check("sb_commit_expected", (exp_q.size() > 0 && exp_q[0].kind == EV_COMMIT), 1'b1);
      if (exp_q.size() > 0 && exp_q[0].kind == EV_COMMIT) void'(exp_q.pop_front());
    end
    if (bus.oErr === 1'b1 && !prev_err) begin
      err_log.push_back(n);
      check("sb_err_expected", (exp_q.size() > 0 && exp_q[0].kind == EV_ERR), 1'b1);
      if (exp_q.size() > 0 && exp_q[0].kind == EV_ERR) void'(exp_q.pop_front());
    end
    prev_wr  = (bus.WrEn === 1'b1);
    prev_err = (bus.oErr === 1'b1);
  endtask

  // One cycle: sample on the falling edge, update the FIFO just after the
  // rising edge, return 2 time units after the rising edge for driving.
  task automatic step();
    @(negedge CLK);
    sample();
    @(posedge CLK);
    #1;
    if (pop_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
    drive_fifo();
    #1;
  endtask

  task automatic run(input int k);
    repeat (k) step();
  endtask

  // ---------------- directed tests ----------------
  int rb, wb, cb, eb, r0, w0;
  logic [2:0] t2_addr [4];
  logic [7:0] t2_data [4];
  logic [2:0] t4_addr [3];
  logic [7:0] t4_data [3];

  initial begin
    RSTn        = 1'b0;
    bus.iHold   = 1'b0;
    bus.iErrClr = 1'b0;
    drive_fifo();
    @(posedge CLK);
    #2;

    // Reset state, with the FIFO already holding packet 1.
    push(8'hA1); push(8'h11); push(8'h22);
    run(2);
    check("rst_rinc", bus.RINC, 1'b0);
    check("rst_wren", bus.WrEn, 1'b0);
    check("rst_regaddr", bus.RegAddr, 3'd0);
    check("rst_data", bus.D7_D0, 8'h00);
    check("rst_commit", bus.oCommit, 1'b0);
    check("rst_busy", bus.oBusy, 1'b0);
    check("rst_err", bus.oErr, 1'b0);

    // Test 1: 0xA1 -> addr 2, N=2, no commit.
    rb = rinc_log.size(); wb = wr_log.size(); cb = commit_log.size();
    RSTn = 1'b1;
    run(8);
    check("t1_rinc_count", rinc_log.size() - rb, 3);
    check("t1_wr_count", wr_log.size() - wb, 2);
    if (rinc_log.size() - rb >= 1 && wr_log.size() - wb >= 2) begin
      r0 = rinc_log[rb];
      check("t1_first_wr_latency", wr_log[wb] - r0, 2);
      check("t1_wr_spacing", wr_log[wb+1] - wr_log[wb], 2);
      check("t1_wr0_addr", wr_addr_log[wb], 3'd2);
      check("t1_wr0_data", wr_data_log[wb], 8'h11);
      check("t1_wr1_addr", wr_addr_log[wb+1], 3'd3);
      check("t1_wr1_data", wr_data_log[wb+1], 8'h22);
      check("t1_busy_before_idle", busy_hist[r0+4], 1'b1);
      check("t1_idle_after_5", busy_hist[r0+5], 1'b0);
    end
    check("t1_no_commit", commit_log.size() - cb, 0);

    // Test 2: 0xEB -> addr 6, commit, N=4: addresses wrap 6,7,0,1.
    t2_addr = '{3'd6, 3'd7, 3'd0, 3'd1};
    t2_data = '{8'h01, 8'h02, 8'h03, 8'h04};
    rb = rinc_log.size(); wb = wr_log.size(); cb = commit_log.size();
    push(8'hEB); push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    run(14);
    check("t2_wr_count", wr_log.size() - wb, 4);
    check("t2_commit_count", commit_log.size() - cb, 1);
    if (wr_log.size() - wb >= 4 && commit_log.size() - cb >= 1) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("t2_wr%0d_addr", i), wr_addr_log[wb+i], t2_addr[i]);
        check($sformatf("t2_wr%0d_data", i), wr_data_log[wb+i], t2_data[i]);
      end
      check("t2_commit_after_4th_wr", commit_log[cb] - wr_log[wb+3], 1);
      r0 = rinc_log[rb];
      check("t2_busy_in_commit", busy_hist[r0+9], 1'b1);
      check("t2_idle_after_10", busy_hist[r0+10], 1'b0);
    end

    // Test 3: bad marker, then a good packet, then clear; then error vs clear.
    rb = rinc_log.size(); wb = wr_log.size();
    push(8'h05);
    run(3);
    check("t3_bad_popped", rinc_log.size() - rb, 1);
    check("t3_err_set", bus.oErr, 1'b1);
    check("t3_no_wr", wr_log.size() - wb, 0);
    check("t3_not_busy", bus.oBusy, 1'b0);
    push(8'h90); push(8'h5A);
    run(6);
    check("t3_next_wr_count", wr_log.size() - wb, 1);
    if (wr_log.size() - wb >= 1) begin
      check("t3_next_addr", wr_addr_log[wb], 3'd1);
      check("t3_next_data", wr_data_log[wb], 8'h5A);
    end
    check("t3_err_sticky", bus.oErr, 1'b1);
    bus.iErrClr = 1'b1;
    run(1);
    bus.iErrClr = 1'b0;
    check("t3_err_cleared", bus.oErr, 1'b0);
    bus.iErrClr = 1'b1;
    push(8'h05);
    run(1);
    bus.iErrClr = 1'b0;
    check("t3_err_beats_clear", bus.oErr, 1'b1);
    run(2);
    bus.iErrClr = 1'b1;
    run(1);
    bus.iErrClr = 1'b0;
    check("t3_err_cleared2", bus.oErr, 1'b0);

    // Test 4: 0xC2 -> addr 4, N=3, iHold for 10 cycles after byte 1.
    t4_addr = '{3'd4, 3'd5, 3'd6};
    t4_data = '{8'hA0, 8'hB0, 8'hC0};
    wb = wr_log.size();
    push(8'hC2); push(8'hA0);
    run(6);
    bus.iHold = 1'b1;
    push(8'hB0); push(8'hC0);
    rb = rinc_log.size(); w0 = wr_log.size();
    run(10);
    check("t4_no_rinc_in_hold", rinc_log.size() - rb, 0);
    check("t4_no_wr_in_hold", wr_log.size() - w0, 0);
    check("t4_busy_in_hold", bus.oBusy, 1'b1);
    bus.iHold = 1'b0;
    run(8);
    check("t4_wr_count", wr_log.size() - wb, 3);
    if (wr_log.size() - wb >= 3) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("t4_wr%0d_addr", i), wr_addr_log[wb+i], t4_addr[i]);
        check($sformatf("t4_wr%0d_data", i), wr_data_log[wb+i], t4_data[i]);
      end
    end
    check("t4_idle", bus.oBusy, 1'b0);

`ifdef CFG_TIMEOUT_EN
    // Test 5: 0x82 -> addr 0, N=3, only one data byte ever arrives.
    wb = wr_log.size(); cb = commit_log.size(); eb = err_log.size();
    push(8'h82); push(8'h77);
    model_timeout();
    run(25);
    check("t5_wr_count", wr_log.size() - wb, 1);
    check("t5_err_count", err_log.size() - eb, 1);
    if (wr_log.size() - wb >= 1 && err_log.size() - eb >= 1) begin
      w0 = wr_log[wb];
      check("t5_wr_addr", wr_addr_log[wb], 3'd0);
      check("t5_wr_data", wr_data_log[wb], 8'h77);
      check("t5_err_after_16_starved", err_log[eb] - w0, 17);
      check("t5_busy_while_starved", busy_hist[w0+16], 1'b1);
      check("t5_busy_falls", busy_hist[w0+17], 1'b0);
    end
    check("t5_no_commit", commit_log.size() - cb, 0);
    check("t5_err_set", bus.oErr, 1'b1);
    bus.iErrClr = 1'b1;
    run(1);
    bus.iErrClr = 1'b0;
`endif

    // Test 6: asynchronous reset while waiting in LOAD, with oErr set.
    push(8'h05);
    run(3);
    push(8'hA1); push(8'h33);
    run(5);
    check("t6_pre_busy", bus.oBusy, 1'b1);
    check("t6_pre_addr", bus.RegAddr, 3'd2);
    check("t6_pre_data", bus.D7_D0, 8'h33);
    check("t6_pre_err", bus.oErr, 1'b1);
    RSTn = 1'b0;
    #1;
    check("t6_rst_rinc", bus.RINC, 1'b0);
    check("t6_rst_wren", bus.WrEn, 1'b0);
    check("t6_rst_addr", bus.RegAddr, 3'd0);
    check("t6_rst_data", bus.D7_D0, 8'h00);
    check("t6_rst_commit", bus.oCommit, 1'b0);
    check("t6_rst_busy", bus.oBusy, 1'b0);
    check("t6_rst_err", bus.oErr, 1'b0);
    // The FIFO is reset alongside; the abandoned packet is forgotten.
    fifo_q.delete();
    drive_fifo();
    exp_q.delete();
    p_left = 0;
    run(2);
    RSTn = 1'b1;
    rb = rinc_log.size(); wb = wr_log.size();
    run(3);
    check("t6_quiet_after_rst", rinc_log.size() - rb, 0);
    push(8'h90); push(8'h5A);
    run(6);
    check("t6_recover_wr", wr_log.size() - wb, 1);
    if (wr_log.size() - wb >= 1) begin
      check("t6_recover_addr", wr_addr_log[wb], 3'd1);
      check("t6_recover_data", wr_data_log[wb], 8'h5A);
    end

    run(2);
    check("sb_all_events_seen", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_fir_cfg_sequencer

// File: doc/fir_cfg_sequencer.md
Name: fir_cfg_sequencer

Overview:
- Sequences configuration writes from the config FIFO read port into the FIR filter's 8-entry register bank.
- Parses byte packets from the FIFO: one header byte, then N data bytes.
- Writes the data bytes to consecutive register addresses, one WrEn pulse per byte.
- Stalls while the filter is busy, flags malformed packets, and pulses a commit strobe so the filter can apply a coefficient set atomically.

Parameters:
- ADDR_W, 3: register address width; the bank has 2^ADDR_W entries.
- DATA_W, 8: data byte width.
- TIMEOUT_CYC, 255: starvation limit in cycles; used only when CFG_TIMEOUT_EN is defined.

Ports:
- CLK  input  1  single clock, same as the FIFO read clock.
- RSTn  input  1  asynchronous active-low reset.
- Empty  input  1  FIFO empty flag.
- Data  input  DATA_W  FIFO read data; show-ahead, valid whenever Empty=0.
- RINC  output  1  FIFO read increment; pops one byte per cycle asserted.
- iHold  input  1  filter busy; no byte is consumed while iHold=1.
- iErrClr  input  1  clears oErr.
- WrEn  output  1  register write strobe, one cycle per byte.
- RegAddr  output  ADDR_W  register write address.
- D7_D0  output  DATA_W  register write data.
- oCommit  output  1  one-cycle pulse after the last byte of a packet whose commit bit is set.
- oBusy  output  1  high whenever state != IDLE.
- oErr  output  1  sticky packet error.

Behaviour:
- Reset (async, RSTn=0): state=IDLE; RINC=0, WrEn=0, RegAddr=0, D7_D0=0, oCommit=0, oErr=0, internal count=0.
- RINC is combinational from state, Empty and iHold. It is never asserted when Empty=1. All other outputs are registered.
- Header byte format:
  - [7] marker, must be 1.
  - [6:4] start address.
  - [3] commit flag.
  - [2:0] N-1, giving N = 1..8.
- States:
  - IDLE: if Empty=0, assert RINC and pop the header.
    - Data[7]=0: set oErr, stay in IDLE. The byte is discarded.
    - Data[7]=1: latch addr, cnt=Data[2:0] and the commit flag, then go to LOAD.
  - LOAD: if Empty=0 and iHold=0, assert RINC, register D7_D0=Data and RegAddr=addr, then go to WR. Otherwise wait in LOAD.
  - WR: WrEn=1 for exactly this cycle.
    - cnt==0: go to COMMIT if the commit flag is set, else to IDLE.
    - otherwise: cnt-1, addr+1 modulo 2^ADDR_W, go to LOAD.
  - COMMIT: oCommit=1 for one cycle, then go to IDLE.
- Latency:
  - WrEn rises the cycle after the RINC cycle that popped the byte.
  - Best case for an N-byte packet is 1+2N cycles, plus 1 cycle if commit is set.
- Address wrap: start 6 with N=4 writes 6, 7, 0, 1.
- iHold rising mid-packet: the sequencer freezes in LOAD. A WR cycle already in progress completes. No byte is lost.
- iErrClr and an error event in the same cycle: the error wins, oErr=1.
- RSTn asserted mid-packet: the packet is abandoned immediately. Remaining FIFO bytes are later parsed as headers, so the FIFO must be reset alongside.

Optional Feature:
- Macro: CFG_TIMEOUT_EN.
- When defined:
  - A counter runs while in LOAD with Empty=1 and iHold=0.
  - When the counter reaches TIMEOUT_CYC: set oErr, drop the remaining count, go to IDLE with no commit.
  - The counter clears on any pop or on leaving LOAD.
- When undefined: LOAD waits indefinitely and no counter is synthesised.

Test Plan:
- Header 0xA1 (addr 2, commit=0, N=2) then data 0x11, 0x22 with the FIFO pre-filled:
  - two WrEn pulses, (2,0x11) then (3,0x22), 2 cycles apart;
  - no oCommit; back in IDLE 5 cycles after the first RINC.
- Header 0xEB (addr 6, commit=1, N=4) then data 0x01..0x04:
  - writes to addresses 6, 7, 0, 1;
  - oCommit pulses the cycle after the 4th WrEn.
- Header 0x05 (marker 0):
  - byte popped, oErr=1, no WrEn;
  - a following valid packet is processed normally;
  - iErrClr=1 for one cycle clears oErr.
- iHold=1 for 10 cycles between data bytes 1 and 2 of an N=3 packet:
  - RINC=0 and WrEn=0 throughout the hold;
  - after release, all 3 writes complete with correct addresses and data.
- With CFG_TIMEOUT_EN and TIMEOUT_CYC=16, header 0x82 followed by only 1 data byte:
  - one WrEn;
  - oErr=1 after 16 starved cycles;
  - oBusy falls; no oCommit.
- RSTn pulsed low during LOAD: all outputs return to their reset values immediately, asynchronously.
